toy_fetch_queue_mc: RTL and testbench

//  Parametrised multi-channel fetch queue between the fetch filter and decode/rename.

---
 rtl/toy_fetch_queue_mc.sv | 157 +++++++++++++++
 tb/tb_toy_fetch_queue_mc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_fetch_queue_mc.sv
// toy_fetch_queue_mc: multi-channel in-order fetch queue between the fetch
// filter and decode/rename. Up to WR_CH compacted writes and RD_CH in-order
// reads per cycle. Read channels are gated by a commit-queue credit counter,
// and each read channel carries a wrapping instruction index.
// Optional build macro TOY_FQ_PERF_CNT_EN adds saturating performance
// counters (full cycles, credit-stall cycles, occupancy high-water mark).
// Handshake: a write group transfers when wr_vld & wr_rdy; wr_rdy depends
// only on registered occupancy. Read channel i transfers when rd_vld[i] &
// rd_rdy[i] and every lower channel also transferred; rd_vld never looks at
// rd_rdy.
module toy_fetch_queue_mc #(
  parameter int DEPTH     = 128,
  parameter int WR_CH     = 4,
  parameter int RD_CH     = 8,
  parameter int PLD_W     = 128,
  parameter int CMT_DEPTH = 64,
  parameter int IDX_W     = 7,
  parameter int REL_W     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cancel_en,
  input  logic                     wr_vld,
  output logic                     wr_rdy,
  input  logic [WR_CH-1:0]         wr_en,
  input  logic [WR_CH*PLD_W-1:0]   wr_pld,
  output logic [RD_CH-1:0]         rd_vld,
  input  logic [RD_CH-1:0]         rd_rdy,
  output logic [RD_CH*PLD_W-1:0]   rd_pld,
  output logic [RD_CH*IDX_W-1:0]   rd_idx,
  input  logic                     crdt_rel_en,
  input  logic [REL_W-1:0]         crdt_rel_num,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef TOY_FQ_PERF_CNT_EN
  ,
  output logic [31:0]              perf_full_cyc,
  output logic [31:0]              perf_crdt_stall_cyc,
  output logic [$clog2(DEPTH):0]   perf_hwm
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CMT_W = $clog2(CMT_DEPTH) + 1;
  localparam int N_W   = $clog2(RD_CH) + 1;
  localparam int SUM_W = CMT_W + REL_W;

  logic [PLD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic [CMT_W-1:0] r_cmt;
  logic [IDX_W-1:0] r_idx_base;

  logic             w_wr_fire;
  logic [PTR_W-1:0] w_wr_off [WR_CH];
  logic [OCC_W-1:0] w_wr_cnt;
  logic [OCC_W-1:0] w_wr_num;
  logic [N_W-1:0]   w_n;
  logic             w_run;
  logic [SUM_W-1:0] w_cmt_sum;
  logic [CMT_W-1:0] w_cmt_next;
  logic [OCC_W-1:0] w_occ_next;

  assign wr_rdy    = (OCC_W'(DEPTH) - r_occ) >= OCC_W'(WR_CH);
  assign w_wr_fire = wr_vld & wr_rdy;
  assign occupancy = r_occ;

  // Compact enabled write channels: channel i lands at wr_ptr + (enabled channels below i).
  always_comb begin
    w_wr_cnt = '0;
    for (int i = 0; i < WR_CH; i++) begin
      w_wr_off[i] = r_wr_ptr + PTR_W'(w_wr_cnt);
      if (wr_en[i]) w_wr_cnt = w_wr_cnt + OCC_W'(1);
    end
    w_wr_num = w_wr_fire ? w_wr_cnt : '0;
  end

  // Read presentation from registered state, plus accept count from the leading run of transfers.
  always_comb begin
    rd_vld = '0;
    rd_pld = '0;
    rd_idx = '0;
    w_n    = '0;
    w_run  = 1'b1;
    for (int i = 0; i < RD_CH; i++) begin
      rd_vld[i] = (OCC_W'(i) < r_occ) && (CMT_W'(i) < r_cmt);
      rd_pld[i*PLD_W +: PLD_W] = r_mem[r_rd_ptr + PTR_W'(i)];
      rd_idx[i*IDX_W +: IDX_W] = r_idx_base + IDX_W'(i);
      w_run = w_run & rd_vld[i] & rd_rdy[i];
      if (w_run) w_n = w_n + N_W'(1);
    end
  end

  // Next credit count (released minus consumed, capped at the full pool) and next occupancy.
  always_comb begin
    w_cmt_sum  = SUM_W'(r_cmt) + (crdt_rel_en ? SUM_W'(crdt_rel_num) : SUM_W'(0)) - SUM_W'(w_n);
    w_cmt_next = (w_cmt_sum > SUM_W'(CMT_DEPTH)) ? CMT_W'(CMT_DEPTH) : w_cmt_sum[CMT_W-1:0];
    w_occ_next = cancel_en ? '0 : (r_occ + w_wr_num - OCC_W'(w_n));
  end

  // Queue control state; cancel overrides any same-cycle write, read or release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_cmt      <= CMT_W'(CMT_DEPTH);
      r_idx_base <= '0;
    end else if (cancel_en) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_cmt      <= CMT_W'(CMT_DEPTH);
      r_idx_base <= '0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + PTR_W'(w_wr_num);
      r_rd_ptr   <= r_rd_ptr + PTR_W'(w_n);
      r_occ      <= w_occ_next;
      r_cmt      <= w_cmt_next;
      r_idx_base <= r_idx_base + IDX_W'(w_n);
    end
  end

  // Payload array: no reset, only entries covered by occupancy are ever observed.
  always_ff @(posedge clk) begin
    if (w_wr_fire && !cancel_en) begin
      for (int i = 0; i < WR_CH; i++) begin
        if (wr_en[i]) r_mem[w_wr_off[i]] <= wr_pld[i*PLD_W +: PLD_W];
      end
    end
  end

`ifdef TOY_FQ_PERF_CNT_EN
  logic [31:0]      r_full_cyc;
  logic [31:0]      r_stall_cyc;
  logic [OCC_W-1:0] r_hwm;

  // Saturating performance counters; cleared by rst_n only, untouched by cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full_cyc  <= '0;
      r_stall_cyc <= '0;
      r_hwm       <= '0;
    end else begin
      if (wr_vld && !wr_rdy && (r_full_cyc != '1)) r_full_cyc <= r_full_cyc + 32'd1;
      if ((r_occ != '0) && (r_cmt == '0) && (r_stall_cyc != '1)) r_stall_cyc <= r_stall_cyc + 32'd1;
      if (w_occ_next > r_hwm) r_hwm <= w_occ_next;
    end
  end

  assign perf_full_cyc       = r_full_cyc;
  assign perf_crdt_stall_cyc = r_stall_cyc;
  assign perf_hwm            = r_hwm;
`endif

endmodule

// File: tb/tb_toy_fetch_queue_mc.sv
// Bench for toy_fetch_queue_mc: a vector table for the basic write/read
// patterns, then hand-written sequences for cancel, credit exhaustion and
// saturation, full/wrap fill-drain loops and an asynchronous mid-run reset.
module tb_toy_fetch_queue_mc;
  localparam int DEPTH = 128, WR_CH = 4, RD_CH = 8, PLD_W = 128;
  localparam int CMT_DEPTH = 64, IDX_W = 7, REL_W = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   cancel_en;
  logic                   wr_vld;
  logic                   wr_rdy;
  logic [WR_CH-1:0]       wr_en;
  logic [WR_CH*PLD_W-1:0] wr_pld;
  logic [RD_CH-1:0]       rd_vld;
  logic [RD_CH-1:0]       rd_rdy;
  logic [RD_CH*PLD_W-1:0] rd_pld;
  logic [RD_CH*IDX_W-1:0] rd_idx;
  logic                   crdt_rel_en;
  logic [REL_W-1:0]       crdt_rel_num;
  logic [7:0]             occupancy;
`ifdef TOY_FQ_PERF_CNT_EN
  logic [31:0]            perf_full_cyc;
  logic [31:0]            perf_crdt_stall_cyc;
  logic [7:0]             perf_hwm;
`endif

  toy_fetch_queue_mc dut (
    .clk(clk), .rst_n(rst_n), .cancel_en(cancel_en),
    .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_en(wr_en), .wr_pld(wr_pld),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_pld(rd_pld), .rd_idx(rd_idx),
    .crdt_rel_en(crdt_rel_en), .crdt_rel_num(crdt_rel_num),
    .occupancy(occupancy)
`ifdef TOY_FQ_PERF_CNT_EN
    , .perf_full_cyc(perf_full_cyc), .perf_crdt_stall_cyc(perf_crdt_stall_cyc),
    .perf_hwm(perf_hwm)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and reference state
  int               n_chk = 0;
  int               n_err = 0;
  logic [PLD_W-1:0] exp_q[$];
  int               m_occ, m_cmt, m_peak, m_full, m_stall, pay_ctr;
  logic [6:0]       m_idx;

  typedef struct {
    logic       wv;
    logic [3:0] we;
    logic [7:0] rr;
    int         occ;
    logic [7:0] vld;
    logic [6:0] idx0;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    exp_q.delete();
    m_occ = 0;
    m_cmt = CMT_DEPTH;
    m_idx = '0;
  endtask

  // One cycle: check state-derived outputs, drive inputs, clock, advance the model.
  task automatic step(input logic can, input logic wv, input logic [3:0] we,
                      input logic [7:0] rr, input logic re, input logic [3:0] rn);
    int               vis;
    int               n;
    logic             er;
    logic             run;
    logic [7:0]       ev;
    logic [6:0]       ei;
    logic [31:0]      tmp;
    logic [PLD_W-1:0] p [WR_CH];
    vis = m_occ;
    if (m_cmt < vis) vis = m_cmt;
    if (vis > RD_CH) vis = RD_CH;
    ev = 8'((1 << vis) - 1);
    er = (DEPTH - m_occ) >= WR_CH;
    chk("occupancy", 128'(occupancy), 128'(m_occ));
    chk("wr_rdy", 128'(wr_rdy), 128'(er));
    chk("rd_vld", 128'(rd_vld), 128'(ev));
    for (int i = 0; i < vis; i++) begin
      ei = m_idx + 7'(i);
      chk("rd_pld", rd_pld[i*PLD_W +: PLD_W], exp_q[i]);
      chk("rd_idx", 128'(rd_idx[i*IDX_W +: IDX_W]), 128'(ei));
    end
    if (wv && !er) m_full++;
    if (m_occ > 0 && m_cmt == 0) m_stall++;
    for (int c = 0; c < WR_CH; c++) begin
      tmp  = 32'(pay_ctr * 4 + c);
      p[c] = {4{tmp}};
      wr_pld[c*PLD_W +: PLD_W] = p[c];
    end
    pay_ctr++;
    cancel_en    = can;
    wr_vld       = wv;
    wr_en        = we;
    rd_rdy       = rr;
    crdt_rel_en  = re;
    crdt_rel_num = rn;
    @(posedge clk);
    #1;
    if (can) begin
      m_reset();
    end else begin
      n = 0;
      run = 1'b1;
      for (int i = 0; i < RD_CH; i++) begin
        run = run & ev[i] & rr[i];
        if (run) n++;
      end
      for (int j = 0; j < n; j++) void'(exp_q.pop_front());
      m_cmt = m_cmt + (re ? int'(rn) : 0) - n;
      if (m_cmt > CMT_DEPTH) m_cmt = CMT_DEPTH;
      m_idx = m_idx + 7'(n);
      if (wv && er) begin
        for (int c = 0; c < WR_CH; c++) if (we[c]) exp_q.push_back(p[c]);
      end
      m_occ = exp_q.size();
    end
    if (m_occ > m_peak) m_peak = m_occ;
  endtask

  initial begin
    // vector table: {wr_vld, wr_en, rd_rdy, occupancy, rd_vld, rd_idx[0]} after the cycle
    tbl[0] = '{1'b1, 4'b1011, 8'h00, 3, 8'h07, 7'd0};
    tbl[1] = '{1'b1, 4'b1111, 8'h00, 7, 8'h7F, 7'd0};
    tbl[2] = '{1'b1, 4'b0001, 8'h00, 8, 8'hFF, 7'd0};
    tbl[3] = '{1'b1, 4'b0000, 8'hF7, 5, 8'h1F, 7'd3};
    tbl[4] = '{1'b0, 4'b1111, 8'hFF, 0, 8'h00, 7'd8};
    tbl[5] = '{1'b1, 4'b0110, 8'hFF, 2, 8'h03, 7'd8};
    tbl[6] = '{1'b1, 4'b1000, 8'h02, 3, 8'h07, 7'd8};
    tbl[7] = '{1'b0, 4'b0000, 8'h01, 2, 8'h03, 7'd9};

    rst_n = 1'b0; cancel_en = 1'b0; wr_vld = 1'b0; wr_en = '0; wr_pld = '0;
    rd_rdy = '0; crdt_rel_en = 1'b0; crdt_rel_num = '0;
    m_reset(); m_peak = 0; m_full = 0; m_stall = 0; pay_ctr = 0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("reset_occ", 128'(occupancy), 128'(0));
    chk("reset_wr_rdy", 128'(wr_rdy), 128'(1));
    chk("reset_rd_vld", 128'(rd_vld), 128'(0));

    // table-driven basic write/compaction/partial-accept patterns
    for (int v = 0; v < 8; v++) begin
      step(1'b0, tbl[v].wv, tbl[v].we, tbl[v].rr, 1'b0, 4'd0);
      chk("tbl_occ", 128'(occupancy), 128'(tbl[v].occ));
      chk("tbl_rd_vld", 128'(rd_vld), 128'(tbl[v].vld));
      chk("tbl_idx0", 128'(rd_idx[IDX_W-1:0]), 128'(tbl[v].idx0));
    end

    // cancel beats a same-cycle write, 4 accepts and a release
    step(1'b0, 1'b1, 4'hF, 8'h00, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'hF, 8'h0F, 1'b1, 4'd3);
    chk("cancel_occ", 128'(occupancy), 128'(0));
    chk("cancel_rd_vld", 128'(rd_vld), 128'(0));
    step(1'b0, 1'b1, 4'b0001, 8'h00, 1'b0, 4'd0);
    chk("cancel_idx0", 128'(rd_idx[IDX_W-1:0]), 128'(0));

    // credit exhaustion: 62 credits consumed leaves two channels open
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 4'hF, 8'h00, 1'b0, 4'd0);
    for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 4'h0, 8'hFF, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'h0, 8'h3F, 1'b0, 4'd0);
    chk("crdt_62_vld", 128'(rd_vld), 128'(8'h03));
    step(1'b0, 1'b0, 4'h0, 8'h03, 1'b1, 4'd5);
    chk("crdt_rel_vld", 128'(rd_vld), 128'(8'h1F));
    step(1'b0, 1'b0, 4'h0, 8'hFF, 1'b0, 4'd0);
    chk("crdt_zero_vld", 128'(rd_vld), 128'(8'h00));
    step(1'b0, 1'b0, 4'h0, 8'hFF, 1'b0, 4'd0);
    // release 75 credits; the pool caps at 64
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'd15);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 4'hF, 8'h00, 1'b0, 4'd0);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 4'h0, 8'hFF, 1'b0, 4'd0);
    chk("crdt_sat_occ", 128'(occupancy), 128'(28));
    chk("crdt_sat_vld", 128'(rd_vld), 128'(8'h00));
    step(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'd0);

    // full boundary
    for (int k = 0; k < 32; k++) step(1'b0, 1'b1, 4'hF, 8'h00, 1'b0, 4'd0);
    chk("full_occ", 128'(occupancy), 128'(128));
    chk("full_wr_rdy", 128'(wr_rdy), 128'(0));
    step(1'b0, 1'b1, 4'hF, 8'h00, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'h0, 8'h0F, 1'b0, 4'd0);
    chk("after_read4_wr_rdy", 128'(wr_rdy), 128'(1));

    // three fill/drain passes: pointers and rd_idx wrap with data checked throughout
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 40 && m_occ <= DEPTH - WR_CH; k++)
        step(1'b0, 1'b1, 4'hF, 8'h00, 1'b0, 4'd0);
      chk("fill_wr_rdy", 128'(wr_rdy), 128'(0));
      for (int k = 0; k < 40 && m_occ > 0; k++)
        step(1'b0, 1'b0, 4'h0, 8'hFF, 1'b1, 4'd8);
      chk("drain_occ", 128'(occupancy), 128'(0));
    end

`ifdef TOY_FQ_PERF_CNT_EN
    chk("perf_full_cyc", 128'(perf_full_cyc), 128'(m_full));
    chk("perf_crdt_stall_cyc", 128'(perf_crdt_stall_cyc), 128'(m_stall));
    chk("perf_hwm", 128'(perf_hwm), 128'(m_peak));
    chk("perf_hwm_peak", 128'(perf_hwm), 128'(128));
`endif

    // asynchronous reset in the middle of a cycle
    step(1'b0, 1'b1, 4'hF, 8'h00, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'hF, 8'h00, 1'b0, 4'd0);
    cancel_en = 1'b0; wr_vld = 1'b0; wr_en = '0; rd_rdy = '0; crdt_rel_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_occ", 128'(occupancy), 128'(0));
    chk("async_rst_rd_vld", 128'(rd_vld), 128'(0));
    chk("async_rst_wr_rdy", 128'(wr_rdy), 128'(1));
    chk("async_rst_idx0", 128'(rd_idx[IDX_W-1:0]), 128'(0));
`ifdef TOY_FQ_PERF_CNT_EN
    chk("async_rst_hwm", 128'(perf_hwm), 128'(0));
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    m_reset();
    step(1'b0, 1'b1, 4'b0101, 8'h00, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'h0, 8'h01, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
